// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// Drives the latch enables/flushes and the PC enable, and runs the
// RUN/DWAIT/DRAIN/HALTED halt-drain state machine.
// Optional feature macro: STALL_CNT_EN adds 32-bit stall cycle counters.
module pipeline_ctrl (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       mem_dREN,
  input  logic       mem_dWEN,
  input  logic       ex_MemToReg,
  input  logic [4:0] ex_wsel,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_branch_taken,
  input  logic       id_jump,
  input  logic       ex_halt,
  input  logic       wb_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       halt
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] dstall_cycles,
  output logic [31:0] istall_cycles,
  output logic [31:0] lu_cycles
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t r_state;
  state_t w_nextState;
  logic   r_retDrain;
  logic   w_nextRet;
  logic   r_halt;

  logic w_dstall;
  logic w_lu;
  logic w_hazard;
  logic w_draining;
  logic w_rule3;

  assign w_dstall   = (mem_dREN | mem_dWEN) & ~dhit;
  assign w_lu       = ex_MemToReg & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (ex_wsel == id_rt));
  assign w_hazard   = w_lu | ~ihit;
  assign w_draining = (r_state == DRAIN) | ((r_state == DWAIT) & r_retDrain);
  assign w_rule3    = ~w_dstall & ~ex_branch_taken & w_hazard;
  assign halt       = r_halt;

  // Latch/PC controls: reset bubbles everything, a dcache stall freezes
  // everything, otherwise branch > load-use/icache miss > jump, with the
  // drain override keeping new instructions out of the pipeline.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!nRST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if ((r_state != HALTED) && !w_dstall) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_hazard) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
      if (w_draining) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  // Next-state logic; a halt that advances out of EX on the dhit cycle of
  // a RUN-originated miss still starts the drain.
  always_comb begin
    w_nextState = r_state;
    w_nextRet   = r_retDrain;
    case (r_state)
      RUN: begin
        if (w_dstall) begin
          w_nextState = DWAIT;
          w_nextRet   = 1'b0;
        end else if (wb_halt) begin
          w_nextState = HALTED;
        end else if (ex_halt && !ex_branch_taken) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        if (w_dstall) begin
          w_nextState = DWAIT;
          w_nextRet   = 1'b1;
        end else if (wb_halt) begin
          w_nextState = HALTED;
        end
      end
      DWAIT: begin
        if (!w_dstall) begin
          if (wb_halt)
            w_nextState = HALTED;
          else if (r_retDrain || (ex_halt && !ex_branch_taken))
            w_nextState = DRAIN;
          else
            w_nextState = RUN;
        end
      end
      default: w_nextState = HALTED;
    endcase
  end

  // State, return flag and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= RUN;
      r_retDrain <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_retDrain <= w_nextRet;
      if (w_nextState == HALTED)
        r_halt <= 1'b1;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] r_dstallCycles;
  logic [31:0] r_istallCycles;
  logic [31:0] r_luCycles;

  assign dstall_cycles = r_dstallCycles;
  assign istall_cycles = r_istallCycles;
  assign lu_cycles     = r_luCycles;

  // Stall statistics; they stop counting once the CPU has halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dstallCycles <= 32'd0;
      r_istallCycles <= 32'd0;
      r_luCycles     <= 32'd0;
    end else if (r_state != HALTED) begin
      if (w_dstall)
        r_dstallCycles <= r_dstallCycles + 32'd1;
      if (w_rule3 && w_lu)
        r_luCycles <= r_luCycles + 32'd1;
      if (w_rule3 && !w_lu && !ihit)
        r_istallCycles <= r_istallCycles + 32'd1;
    end
  end
`endif

endmodule
